// File: rtl/lin_interp_upsampler_if.sv
`default_nettype none
// ============================================================================
//  Module   : lin_interp_upsampler_if
//  Brief    : AXI-Stream style data channel (tdata/tvalid/tready) with modports
//  Revision : 1.0  initial release
// ============================================================================
interface lin_interp_upsampler_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] tdata;
  logic             tvalid;
  logic             tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/lin_interp_upsampler.sv
`default_nettype none
// ============================================================================
//  Module   : lin_interp_upsampler
//  Brief    : Signed-sample linear interpolator, 2**OSR_LOG2 offset-binary
//             outputs per input, segment-boundary input backpressure
//  Revision : 1.0  initial release
// ============================================================================
module lin_interp_upsampler #(
  parameter int WIDTH    = 16,
  parameter int OSR_LOG2 = 6
) (
  input  wire logic               aclk,
  input  wire logic               arst,
  lin_interp_upsampler_if.slave   s_axis_data,
  lin_interp_upsampler_if.master  m_axis_data,
  output logic                    underrun
);

  localparam int c_ACCW = WIDTH + OSR_LOG2 + 1;
  localparam int c_DW   = WIDTH + 1;
  localparam logic [OSR_LOG2-1:0] c_LAST_PHASE = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                    r_state;
  logic signed [WIDTH-1:0]   r_prev;
  logic signed [WIDTH-1:0]   r_curr;
  logic signed [c_DW-1:0]    r_delta;
  logic signed [c_ACCW-1:0]  r_acc;
  logic [OSR_LOG2-1:0]       r_phase;
  logic [WIDTH-1:0]          r_tdata;
  logic                      r_tvalid;
  logic                      r_underrun;

  state_t                    w_state_nxt;
  logic signed [WIDTH-1:0]   w_prev_nxt;
  logic signed [WIDTH-1:0]   w_curr_nxt;
  logic signed [c_DW-1:0]    w_delta_nxt;
  logic signed [c_ACCW-1:0]  w_acc_nxt;
  logic [OSR_LOG2-1:0]       w_phase_nxt;
  logic                      w_underrun_nxt;

  logic signed [WIDTH-1:0]   w_x;
  logic                      w_run;
  logic                      w_seg_end;
  logic                      w_s_ready;
  logic                      w_s_xfer;
  logic                      w_m_xfer;
  logic [WIDTH-1:0]          w_y;
  logic [WIDTH-1:0]          w_tdata_nxt;
  logic                      w_unused_bits;

  function automatic logic signed [c_ACCW-1:0] f_scale(input logic signed [WIDTH-1:0] v);
    return {{(OSR_LOG2+1){v[WIDTH-1]}}, v} << OSR_LOG2;
  endfunction

  assign w_x       = s_axis_data.tdata;
  assign w_run     = (r_state == ST_RUN);
  assign w_seg_end = (r_phase == c_LAST_PHASE);
  // Inputs are only taken at a segment boundary that is actually advancing.
  assign w_s_ready = w_run ? (w_seg_end & m_axis_data.tready) : 1'b1;
  assign w_s_xfer  = w_s_ready & s_axis_data.tvalid;
  assign w_m_xfer  = w_run & m_axis_data.tready;

  always_comb begin
    w_state_nxt    = r_state;
    w_prev_nxt     = r_prev;
    w_curr_nxt     = r_curr;
    w_delta_nxt    = r_delta;
    w_acc_nxt      = r_acc;
    w_phase_nxt    = r_phase;
    w_underrun_nxt = 1'b0;
    if (!w_run) begin
      if (w_s_xfer) begin
        w_state_nxt = ST_RUN;
        w_prev_nxt  = w_x;
        w_curr_nxt  = w_x;
        w_delta_nxt = '0;
        w_acc_nxt   = f_scale(w_x);
        w_phase_nxt = '0;
      end
    end else if (w_m_xfer) begin
      if (!w_seg_end) begin
        w_acc_nxt   = r_acc + {{OSR_LOG2{r_delta[c_DW-1]}}, r_delta};
        w_phase_nxt = r_phase + OSR_LOG2'(1);
      end else begin
        w_phase_nxt = '0;
        w_prev_nxt  = r_curr;
        w_acc_nxt   = f_scale(r_curr);
        if (w_s_xfer) begin
          w_curr_nxt  = w_x;
          w_delta_nxt = {w_x[WIDTH-1], w_x} - {r_curr[WIDTH-1], r_curr};
        end else begin
          // Starved: hold curr so the output flat-lines until input resumes.
          w_delta_nxt    = '0;
          w_underrun_nxt = 1'b1;
        end
      end
    end
  end

  // Floor of acc / OSR, then MSB flip to offset-binary.
  assign w_y         = w_acc_nxt[OSR_LOG2 +: WIDTH];
  assign w_tdata_nxt = {~w_y[WIDTH-1], w_y[WIDTH-2:0]};

  always_ff @(posedge aclk) begin
    if (arst) begin
      r_state    <= ST_IDLE;
      r_prev     <= '0;
      r_curr     <= '0;
      r_delta    <= '0;
      r_acc      <= '0;
      r_phase    <= '0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prev     <= w_prev_nxt;
      r_curr     <= w_curr_nxt;
      r_delta    <= w_delta_nxt;
      r_acc      <= w_acc_nxt;
      r_phase    <= w_phase_nxt;
      r_tdata    <= (w_state_nxt == ST_RUN) ? w_tdata_nxt : '0;
      r_tvalid   <= (w_state_nxt == ST_RUN);
      r_underrun <= w_underrun_nxt;
    end
  end

  assign s_axis_data.tready = w_s_ready;
  assign m_axis_data.tdata  = r_tdata;
  assign m_axis_data.tvalid = r_tvalid;
  assign underrun           = r_underrun;

  // prev is architectural segment state that the datapath never reads back.
  assign w_unused_bits = ^{r_prev, w_acc_nxt[c_ACCW-1], w_acc_nxt[OSR_LOG2-1:0]};

endmodule
`default_nettype wire

// File: tb/tb_lin_interp_upsampler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lin_interp_upsampler
//  Brief    : Table vectors, directed corner sequences and a randomized run
//             against an interpolation-formula reference for the upsampler
//  Revision : 1.0  initial release
// ============================================================================
module tb_lin_interp_upsampler;

  localparam int W     = 16;
  localparam int A_OSR = 4;
  localparam int B_OSR = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_und;
  logic b_und;

  always #5 clk = ~clk;

  lin_interp_upsampler_if #(.WIDTH(W)) a_s (), a_m (), b_s (), b_m ();

  lin_interp_upsampler #(.WIDTH(W), .OSR_LOG2(2)) u_dut_a (
    .aclk(clk), .arst(rst), .s_axis_data(a_s), .m_axis_data(a_m), .underrun(a_und)
  );

  lin_interp_upsampler #(.WIDTH(W), .OSR_LOG2(6)) u_dut_b (
    .aclk(clk), .arst(rst), .s_axis_data(b_s), .m_axis_data(b_m), .underrun(b_und)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]       x;
    logic [0:3][15:0]  exp;
  } vec_t;

  vec_t tab [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input logic [15:0] d, input logic rdy, input logic und);
    chk({name, "_tvalid"}, a_m.tvalid, 1'b1);
    chk({name, "_tdata"}, a_m.tdata, d);
    chk({name, "_s_tready"}, a_s.tready, rdy);
    chk({name, "_underrun"}, a_und, und);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    a_s.tvalid = 1'b0;
    a_s.tdata  = '0;
    a_m.tready = 1'b1;
    b_s.tvalid = 1'b0;
    b_s.tdata  = '0;
    b_m.tready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] to_off(input int y);
    return 16'(y + 32768);
  endfunction

  // Reference: output k of a segment is floor((prev*OSR + k*(curr-prev))/OSR).
  task automatic run_random(input int ncyc, input int pv, input int plow);
    int  mrun, mp, mc, mk, x, y, lo, hi;
    bit  mund, hs, exp_rdy;
    mrun = 0; mp = 0; mc = 0; mk = 0; mund = 0; hs = 1;
    do_reset();
    for (int n = 0; n < ncyc; n++) begin
      @(negedge clk);
      if (!a_s.tvalid || hs) begin
        a_s.tvalid = ($urandom_range(99) < pv);
        a_s.tdata  = 16'($urandom);
      end
      a_m.tready = ($urandom_range(99) >= plow);
      #1;
      x = $signed(a_s.tdata);
      exp_rdy = (mrun == 0) ? 1'b1 : ((mk == A_OSR - 1) && a_m.tready);
      if (mrun == 0) begin
        chk("rnd_idle_tvalid", a_m.tvalid, 1'b0);
      end else begin
        y  = floor_div(mp * A_OSR + mk * (mc - mp), A_OSR);
        lo = (mp < mc) ? mp : mc;
        hi = (mp < mc) ? mc : mp;
        chk("rnd_tvalid", a_m.tvalid, 1'b1);
        chk($sformatf("rnd_tdata_n%0d", n), a_m.tdata, to_off(y));
        chk("rnd_y_in_range", (y >= lo) && (y <= hi), 1'b1);
      end
      chk($sformatf("rnd_s_tready_n%0d", n), a_s.tready, exp_rdy);
      chk($sformatf("rnd_underrun_n%0d", n), a_und, mund);
      hs   = a_s.tvalid && exp_rdy;
      mund = 1'b0;
      if (mrun == 0) begin
        if (hs) begin
          mrun = 1; mp = x; mc = x; mk = 0;
        end
      end else if (a_m.tready) begin
        if (mk < A_OSR - 1) begin
          mk++;
        end else begin
          mk = 0;
          mp = mc;
          if (a_s.tvalid) mc = x;
          else mund = 1'b1;
        end
      end
    end
    @(negedge clk);
    a_s.tvalid = 1'b0;
    a_m.tready = 1'b1;
  endtask

  initial begin
    int rcount;

    tab[0] = '{x: 16'h0000, exp: {16'h8000, 16'h8000, 16'h8000, 16'h8000}};
    tab[1] = '{x: 16'h0190, exp: {16'h8000, 16'h8064, 16'h80C8, 16'h812C}};
    tab[2] = '{x: 16'h8000, exp: {16'h8190, 16'h612C, 16'h40C8, 16'h2064}};
    tab[3] = '{x: 16'h7FFF, exp: {16'h0000, 16'h3FFF, 16'h7FFF, 16'hBFFF}};
    tab[4] = '{x: 16'h7FFF, exp: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}};
    tab[5] = '{x: 16'h1000, exp: {16'hFFFF, 16'hE3FF, 16'hC7FF, 16'hABFF}};

    // Reset state
    do_reset();
    #1;
    chk("rst_tvalid", a_m.tvalid, 1'b0);
    chk("rst_tdata", a_m.tdata, 16'h0000);
    chk("rst_underrun", a_und, 1'b0);
    chk("rst_s_tready", a_s.tready, 1'b1);
    chk("rst_b_tvalid", b_m.tvalid, 1'b0);

    // Table: back-to-back segments including full-scale ramps
    @(negedge clk);
    a_s.tvalid = 1'b1;
    a_s.tdata  = tab[0].x;
    #1;
    chk("tab_idle_s_tready", a_s.tready, 1'b1);
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (k == 0) begin
          if (i < 5) a_s.tdata = tab[i+1].x;
          else       a_s.tvalid = 1'b0;
        end
        #1;
        chk_a($sformatf("tab_r%0d_k%0d", i, k), tab[i].exp[k], k == 3, 1'b0);
      end
    end

    // Starvation: flat-line with one underrun pulse per starved segment, then resume
    do_reset();
    @(negedge clk);
    a_s.tvalid = 1'b1;
    a_s.tdata  = 16'h0000;
    #1;
    chk("starve_idle_s_tready", a_s.tready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) a_s.tdata = 16'h0190;
      #1;
      chk_a($sformatf("starve_s0_k%0d", k), 16'h8000, k == 3, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) a_s.tvalid = 1'b0;
      #1;
      chk_a($sformatf("starve_s1_k%0d", k), tab[1].exp[k], k == 3, 1'b0);
    end
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (s == 2 && k == 3) begin
          a_s.tvalid = 1'b1;
          a_s.tdata  = 16'h0000;
        end
        #1;
        chk_a($sformatf("starve_hold%0d_k%0d", s, k), 16'h8190, k == 3, k == 0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) a_s.tvalid = 1'b0;
      #1;
      case (k)
        0: chk_a("resume_k0", 16'h8190, 1'b0, 1'b0);
        1: chk_a("resume_k1", 16'h812C, 1'b0, 1'b0);
        2: chk_a("resume_k2", 16'h80C8, 1'b0, 1'b0);
        default: chk_a("resume_k3", 16'h8064, 1'b1, 1'b0);
      endcase
    end

    // Reset mid-segment at phase 2, then a fresh segment
    do_reset();
    @(negedge clk);
    a_s.tvalid = 1'b1;
    a_s.tdata  = 16'h0190;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_s.tvalid = 1'b0;
      #1;
      chk_a($sformatf("mid_pre_k%0d", k), 16'h8190, 1'b0, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    a_s.tvalid = 1'b1;
    a_s.tdata  = 16'h1000;
    #1;
    chk("mid_rst_tvalid", a_m.tvalid, 1'b0);
    chk("mid_rst_tdata", a_m.tdata, 16'h0000);
    chk("mid_rst_s_tready", a_s.tready, 1'b1);
    chk("mid_rst_underrun", a_und, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_s.tvalid = 1'b0;
      #1;
      chk_a($sformatf("mid_post_k%0d", k), 16'h9000, k == 3, 1'b0);
    end

    // Randomized: always-ready downstream, then 20% backpressure
    run_random(400, 60, 0);
    run_random(800, 70, 20);

    // OSR_LOG2=6 instance: constant input over three segments
    do_reset();
    @(negedge clk);
    b_s.tvalid = 1'b1;
    b_s.tdata  = 16'h0123;
    #1;
    chk("b_idle_s_tready", b_s.tready, 1'b1);
    rcount = 0;
    for (int n = 0; n < 3 * B_OSR; n++) begin
      @(negedge clk);
      #1;
      chk($sformatf("b_tvalid_n%0d", n), b_m.tvalid, 1'b1);
      chk($sformatf("b_tdata_n%0d", n), b_m.tdata, 16'h8123);
      chk($sformatf("b_s_tready_n%0d", n), b_s.tready, (n % B_OSR) == B_OSR - 1);
      chk($sformatf("b_underrun_n%0d", n), b_und, 1'b0);
      if (b_s.tready) rcount++;
    end
    chk("b_tready_count", rcount, 3);
    @(negedge clk);
    b_s.tvalid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
